// File: rtl/multi_dataflow_tile_sched.sv
// multi_dataflow_tile_sched
//   Job-level tile scheduler sitting between the register-file logic and the
//   multi_dataflow control FSM. Queues job descriptors and issues one start
//   pulse per tile. It presents per-tile base offsets and advances them by the
//   job strides after each FSM done.
//
// Ports
//   clk_i, rst_i (sync, active-high), clear_i (soft clear, same as rst_i)
//   job_valid_i / job_ready_o     : job descriptor handshake
//   job_n_tiles_i, job_cfg_i      : tile count and configuration ID
//   job_stride_*_i                : per-tile offset increments
//   fsm_start_o / fsm_done_i      : per-tile engine handshake
//   cfg_o, offs_*_o, tile_idx_o   : active job configuration, offsets, tile index
//   evt_tile_o, evt_job_o         : tile / job completion pulses
//   busy_o                        : active job present or queue non-empty
//   perf_cycles_o                 : WAIT_DONE cycles of the last finished job
//
// Build option
//   MULTI_DATAFLOW_TILE_SCHED_PERF_EN : enables the wait-cycle counter;
//   otherwise perf_cycles_o is tied to 0.
//
// state       | meaning
// ------------+------------------------------------------------------
// S_IDLE      | no active job; wait for a queued descriptor
// S_LOAD      | pop queue head into working regs, zero offsets/index
// S_ISSUE     | fsm_start_o pulse for the current tile
// S_WAIT_DONE | wait for fsm_done_i
// S_ADVANCE   | tile done; step offsets and tile index
// S_JOB_END   | job done pulse (plus final tile pulse if any tiles ran)

module multi_dataflow_tile_sched #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16,
  parameter int CFG_W  = 8,
  parameter int QDEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              job_valid_i,
  output logic              job_ready_o,
  input  logic [CNT_W-1:0]  job_n_tiles_i,
  input  logic [CFG_W-1:0]  job_cfg_i,
  input  logic [ADDR_W-1:0] job_stride_in_pel_i,
  input  logic [ADDR_W-1:0] job_stride_in_size_i,
  input  logic [ADDR_W-1:0] job_stride_out_pel_i,
  output logic              fsm_start_o,
  input  logic              fsm_done_i,
  output logic [CFG_W-1:0]  cfg_o,
  output logic [ADDR_W-1:0] offs_in_pel_o,
  output logic [ADDR_W-1:0] offs_in_size_o,
  output logic [ADDR_W-1:0] offs_out_pel_o,
  output logic [CNT_W-1:0]  tile_idx_o,
  output logic              evt_tile_o,
  output logic              evt_job_o,
  output logic              busy_o,
  output logic [31:0]       perf_cycles_o
);

  localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int QC_W   = $clog2(QDEPTH + 1);
  localparam int DESC_W = CFG_W + CNT_W + 3 * ADDR_W;
  localparam logic [QC_W-1:0]  QDEPTH_C = QC_W'(QDEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_WAIT_DONE, S_ADVANCE, S_JOB_END
  } state_e;

  state_e state_q;
  logic   sync_rst;
  assign sync_rst = rst_i | clear_i;

  // ---------------- job queue ----------------
  logic [DESC_W-1:0] mem_q [QDEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [QC_W-1:0]   count_q, count_d;
  logic              ready_q, push, pop;
  logic [DESC_W-1:0] head;

  assign push = job_valid_i & ready_q;
  assign pop  = (state_q == S_LOAD);
  assign head = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {job_cfg_i, job_n_tiles_i, job_stride_in_pel_i,
                                  job_stride_in_size_i, job_stride_out_pel_i};
  end

  // ready is registered from the next count so the pop never reaches it combinationally
  always_ff @(posedge clk_i) begin
    if (sync_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      count_q <= count_d;
      ready_q <= (count_d < QDEPTH_C);
    end
  end

  // ---------------- tile sequencer ----------------
  logic [CNT_W-1:0]  n_tiles_q;
  logic [ADDR_W-1:0] str_in_pel_q, str_in_size_q, str_out_pel_q;

  always_ff @(posedge clk_i) begin
    if (sync_rst) begin
      state_q        <= S_IDLE;
      cfg_o          <= '0;
      n_tiles_q      <= '0;
      str_in_pel_q   <= '0;
      str_in_size_q  <= '0;
      str_out_pel_q  <= '0;
      offs_in_pel_o  <= '0;
      offs_in_size_o <= '0;
      offs_out_pel_o <= '0;
      tile_idx_o     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (count_q != '0) state_q <= S_LOAD;
        S_LOAD: begin
          {cfg_o, n_tiles_q, str_in_pel_q, str_in_size_q, str_out_pel_q} <= head;
          offs_in_pel_o  <= '0;
          offs_in_size_o <= '0;
          offs_out_pel_o <= '0;
          tile_idx_o     <= '0;
          state_q <= (head[3*ADDR_W +: CNT_W] == '0) ? S_JOB_END : S_ISSUE;
        end
        S_ISSUE: state_q <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (fsm_done_i)
            state_q <= (tile_idx_o == n_tiles_q - CNT_W'(1)) ? S_JOB_END : S_ADVANCE;
        end
        S_ADVANCE: begin
          offs_in_pel_o  <= offs_in_pel_o  + str_in_pel_q;
          offs_in_size_o <= offs_in_size_o + str_in_size_q;
          offs_out_pel_o <= offs_out_pel_o + str_out_pel_q;
          tile_idx_o     <= tile_idx_o + CNT_W'(1);
          state_q        <= S_ISSUE;
        end
        S_JOB_END: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  assign job_ready_o = ready_q;
  assign fsm_start_o = (state_q == S_ISSUE);
  assign evt_tile_o  = (state_q == S_ADVANCE) || ((state_q == S_JOB_END) && (n_tiles_q != '0));
  assign evt_job_o   = (state_q == S_JOB_END);
  assign busy_o      = (state_q != S_IDLE) || (count_q != '0);

`ifdef MULTI_DATAFLOW_TILE_SCHED_PERF_EN
  logic [31:0] perf_cnt_q, perf_q;

  always_ff @(posedge clk_i) begin
    if (sync_rst) begin
      perf_cnt_q <= '0;
      perf_q     <= '0;
    end else begin
      if (state_q == S_LOAD)
        perf_cnt_q <= '0;
      else if (state_q == S_WAIT_DONE && perf_cnt_q != '1)
        perf_cnt_q <= perf_cnt_q + 32'd1;
      if (state_q == S_JOB_END) perf_q <= perf_cnt_q;
    end
  end

  assign perf_cycles_o = perf_q;
`else
  assign perf_cycles_o = '0;
`endif

endmodule
